fp_mul_arbiter: RTL
===================

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one fp_mul (2..8).
REQ-002 SHALL have parameter LAT, default 1, fp_mul latency in cycles: 1 = PIPLINE build, 0 = combinational build.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester grant (one-hot or zero).
REQ-007 SHALL have port req_a  input  16*NREQ  FP16 operand a; requester i in bits [16i+15:16i].
REQ-008 SHALL have port req_b  input  16*NREQ  FP16 operand b; same packing as req_a.
REQ-009 SHALL have port mul_a  output  16  operand a to shared fp_mul.
REQ-010 SHALL have port mul_b  output  16  operand b to shared fp_mul.
REQ-011 SHALL have port mul_c  input  16  product from shared fp_mul.
REQ-012 SHALL have port rsp_valid  output  NREQ  per-requester result valid.
REQ-013 SHALL have port rsp_data  output  16*NREQ  per-requester registered result; same packing as req_a.
REQ-014 SHALL have port rsp_ready  input  NREQ  per-requester result accept.
REQ-015 SHALL have port idle  output  1  high when no request in flight and no result pending.

Function
REQ-016 SHALL keep a busy[i] flag per requester: set on grant, cleared on rsp_valid[i] & rsp_ready[i].
REQ-017 SHALL treat requester i as eligible when req_valid[i] & ~busy[i], using registered busy, so at most one outstanding op per requester.
REQ-018 SHALL grant, combinationally, the first eligible index at or after rr_ptr, searching circularly modulo NREQ.
REQ-019 SHALL advance rr_ptr to (granted index + 1) mod NREQ on a grant; rr_ptr SHALL hold when there is no grant.
REQ-020 SHALL treat a transfer as complete when req_valid[i] & req_ready[i] in the same cycle.
REQ-021 SHALL drive mul_a/mul_b from the granted requester's operands in the grant cycle, and 16'h0000 when there is no grant.
REQ-022 SHALL carry a tag {valid, index} through a LAT-deep shift register in step with the fp_mul pipeline.
REQ-023 SHALL, when the tag emerges valid, load mul_c into rsp_data[index] and set rsp_valid[index] on the next edge.
REQ-024 SHALL, when LAT=0, use the grant cycle's tag and mul_c directly, giving a result in rsp_data one cycle after grant.
REQ-025 SHALL have a grant-to-rsp_valid latency of LAT+1 cycles (LAT=1: 2 cycles).
REQ-026 SHALL sustain one issue per cycle across different requesters, with no bubbles.
REQ-027 SHALL hold rsp_valid[i] and rsp_data[i] stable until accepted; the busy flag guarantees no overwrite.
REQ-028 SHALL NOT re-grant requester i in the same cycle its response is accepted; it becomes eligible the following cycle.
REQ-029 SHALL assert idle = ~|busy.
REQ-030 SHALL pass mul_c through unmodified: no rounding, zero or exception handling in this block.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear busy, rr_ptr (to 0), all tag stages, rsp_valid and rsp_data (to 0).
REQ-032 SHALL, during reset, hold req_ready at 0 and mul_a/mul_b at 0, and force idle to 1.
REQ-033 SHALL, on reset mid-operation, discard in-flight tags; fp_mul output arriving after reset SHALL NOT set any rsp_valid.
REQ-034 SHALL grant on the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL be verified with single op (LAT=1): req0 a=0x3C00, b=0x4000 -> req_ready[0] in cycle 0, rsp_valid[0] in cycle 2, rsp_data0=0x4000.
REQ-036 SHALL be verified with all four requesting continuously: grants in order 0,1,2,3, one per cycle; requester 0 is not re-granted until its rsp is accepted.
REQ-037 SHALL be verified with backpressure: req1 0x3E00*0x4000 and rsp_ready[1]=0 for 5 cycles -> rsp_data1=0x4200 held stable, req1 not granted, others still served.
REQ-038 SHALL be verified with fairness: rr_ptr=2 and req0+req3 both valid -> grant 3, then 0.
REQ-039 SHALL be verified with reset mid-flight: rst_n low the cycle after grant -> no rsp_valid after release, idle=1.
REQ-040 SHALL be verified with LAT=0: req2 0xC000*0x3C00 -> rsp_valid[2] one cycle after grant, rsp_data2=0xC000.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one FP16 multiplier among NREQ requesters.
// Each requester has at most one op in flight and gets a held, registered result.
module fp_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_c,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [16*NREQ-1:0]   rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 idle
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] busy_reg, busy_next;
  logic [NREQ-1:0] rsp_valid_reg, rsp_valid_next;
  logic [15:0]     rsp_data_reg  [NREQ];
  logic [15:0]     rsp_data_next [NREQ];
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant_vec;
  logic [IW-1:0]   grant_idx;
  logic            grant_found;
  logic            grant_valid;
  logic            tag_out_valid;
  logic [IW-1:0]   tag_out_idx;

  assign eligible = req_valid & ~busy_reg;

  // Circular search starting at rr_ptr; first eligible index wins.
  always_comb begin : arbitrate
    int j;
    logic [IW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_reg) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IW'(j);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset masks the grant so nothing is issued while rst_n is low.
  assign grant_valid = grant_found & rst_n;

  always_comb begin
    grant_vec = '0;
    mul_a     = 16'h0000;
    mul_b     = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_valid && (grant_idx == IW'(i))) begin
        grant_vec[i] = 1'b1;
        mul_a        = req_a[16*i +: 16];
        mul_b        = req_b[16*i +: 16];
      end
    end
  end

  assign req_ready = grant_vec;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      if (grant_idx == IW'(NREQ-1)) rr_ptr_next = '0;
      else                           rr_ptr_next = grant_idx + IW'(1);
    end
  end

  generate
    if (LAT == 0) begin : g_comb_tag
      assign tag_out_valid = grant_valid;
      assign tag_out_idx   = grant_idx;
    end else begin : g_pipe_tag
      logic [LAT-1:0] tag_valid_reg;
      logic [IW-1:0]  tag_idx_reg [LAT];

      // Tag walks alongside the multiplier pipeline so the product lands on its owner.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid_reg <= '0;
          for (int s = 0; s < LAT; s++) tag_idx_reg[s] <= '0;
        end else begin
          tag_valid_reg[0] <= grant_valid;
          tag_idx_reg[0]   <= grant_idx;
          for (int s = 1; s < LAT; s++) begin
            tag_valid_reg[s] <= tag_valid_reg[s-1];
            tag_idx_reg[s]   <= tag_idx_reg[s-1];
          end
        end
      end

      assign tag_out_valid = tag_valid_reg[LAT-1];
      assign tag_out_idx   = tag_idx_reg[LAT-1];
    end
  endgenerate

  // busy stays set from grant through acceptance, which also blocks overwrite of a held result.
  always_comb begin
    busy_next      = busy_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid_reg[i] && rsp_ready[i]) begin
        rsp_valid_next[i] = 1'b0;
        busy_next[i]      = 1'b0;
      end
      if (grant_vec[i]) busy_next[i] = 1'b1;
      if (tag_out_valid && (tag_out_idx == IW'(i))) begin
        rsp_valid_next[i] = 1'b1;
        rsp_data_next[i]  = mul_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg      <= '0;
      rsp_valid_reg <= '0;
      rr_ptr_reg    <= '0;
      for (int i = 0; i < NREQ; i++) rsp_data_reg[i] <= 16'h0000;
    end else begin
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      rr_ptr_reg    <= rr_ptr_next;
      for (int i = 0; i < NREQ; i++) rsp_data_reg[i] <= rsp_data_next[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rsp_out
      assign rsp_data[16*gi +: 16] = rsp_data_reg[gi];
    end
  endgenerate

  assign rsp_valid = rsp_valid_reg;
  assign idle      = ~|busy_reg;

endmodule
